vc_rr_msg_merge: RTL and testbench
==================================

# vc_rr_msg_merge

Merges `p_num_reqs` latency-insensitive val/rdy message streams onto one output stream, with round-robin fairness and a single pipeline register on the output. It sits between several test sources (for example random-delay sources) or several producer units and one shared consumer such as a test sink or a shared functional unit. It also reports which requester each output message came from. Full throughput: one message per cycle when the output is ready.

## Interface
- `p_msg_nbits`, 8, message width in bits.
- `p_num_reqs`, 4, number of requesters; legal range 2..16.
- `p_src_nbits`, `$clog2(p_num_reqs)`, width of the source-id field; not overridden.

Ports:
- `clk`  in  1  clock; everything updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_val`  in  `p_num_reqs`  per-requester valid; bit i belongs to requester i.
- `in_rdy`  out  `p_num_reqs`  per-requester ready.
- `in_msg`  in  `p_num_reqs*p_msg_nbits`  flattened messages; requester i occupies bits `[i*p_msg_nbits +: p_msg_nbits]`.
- `out_val`  out  1  output message valid.
- `out_rdy`  in  1  output consumer ready.
- `out_msg`  out  `p_msg_nbits`  registered output message.
- `out_src`  out  `p_src_nbits`  index of the requester that produced `out_msg`.
- `num_msgs`  out  32  count of completed output transfers since reset.

## Operation
- **Output register.** State: `full`, `msg_reg`, `src_reg`.
  - `out_val = full`, `out_msg = msg_reg`, `out_src = src_reg`.
- **Accept condition.** `can_accept = !reset && (!full || out_rdy)`.
- **Priority pointer.** `ptr`, width `p_src_nbits`, reset to 0.
  - Requester `ptr` has highest priority; priority then falls in order `ptr+1`, `ptr+2`, … wrapping modulo `p_num_reqs`.
- **Grant.** One-hot `grant` = first asserted `in_val` bit at or after `ptr`, in circular order. `grant` is all zero if no `in_val` bit is set.
- **Ready.** `in_rdy = grant & {p_num_reqs{can_accept}}`. At most one `in_rdy` bit is high in any cycle.
- **Input transfer** on requester i (`in_val[i] && in_rdy[i]`):
  - `msg_reg <= in_msg[i]`, `src_reg <= i`, `full <= 1`.
  - `ptr <= (i+1) mod p_num_reqs`. The wrap for non-power-of-two `p_num_reqs` must be explicit, not bit truncation.
- **Output transfer** (`out_val && out_rdy`) with no input transfer in the same cycle: `full <= 0`; `msg_reg` and `src_reg` keep their values.
- **Simultaneous output and input transfer.** The register is reloaded from the new input and `full` stays 1. No bubble.
- **Held output.** While `out_val && !out_rdy`:
  - `out_msg` and `out_src` are stable.
  - All `in_rdy` bits are 0.
  - `ptr` is unchanged.
- **No transfer cycles.** `ptr` changes only on an input transfer.
- **Message counter.** `num_msgs` increments by 1 on each output transfer and wraps at 2^32.
- **Reset.** Reset at any time, including mid-operation, discards any held message. No input is acknowledged while reset is high.
  - Reset values: `full=0`, `out_val=0`, `msg_reg=0`, `out_msg=0`, `src_reg=0`, `out_src=0`, `ptr=0`, `num_msgs=0`, `in_rdy=0`.

## Timing
- Latency is 1 cycle: a message accepted at edge n appears on `out_val`/`out_msg` after edge n.
- Throughput is 1 message per cycle while `out_rdy` stays high.
- Combinational paths `in_val → in_rdy` and `out_rdy → in_rdy` are permitted.
- No combinational path from any input to `out_val`, `out_msg`, `out_src` or `num_msgs`.
- Fairness: a requester that holds `in_val` is granted within `p_num_reqs` input transfers.

## Structure
- No shared package or typedefs are needed. Widths come only from parameters.
- Sub-module `vc_rr_arb_prio`, placed in the shared arbiters file:
  - Parameter `p_num_reqs`.
  - Inputs `clk`, `reset`, `reqs`, `kin` (kill/enable).
  - Outputs `grants`, `grant_idx`.
  - Holds `ptr` and updates it when `kin` is deasserted and a grant is issued.
- `vc_rr_msg_merge` owns the output register, the message mux (driven by `grant_idx`) and `num_msgs`.
- Provide a `trace` task that prints per-port `in_val`/`in_rdy` state and `out_src:out_msg`, following the standard trace macros.

## Test plan
- **Reset.** Assert reset for 2 cycles with all `in_val=1` → `in_rdy=0000`, `out_val=0`, `out_src=0`, `num_msgs=0`. The cycle after reset falls, `in_rdy=0001`.
- **All requesters valid, `out_rdy=1`,** messages 0x10/0x21/0x32/0x43 on ports 0–3 → `out_src` sequence 0,1,2,3,0,…, one message per cycle, `out_msg` matches port data. After 8 cycles, `num_msgs=8`.
- **Backpressure.** Hold `out_rdy=0` for 3 cycles with `out_val=1`, `out_msg=0x21` → `out_msg` stable, `in_rdy=0000`, `ptr` unchanged. Raising `out_rdy` resumes with port 2.
- **Sparse requests.** Only port 3 valid, then only port 0 valid → port 3 granted, then port 0 granted via the wrap (`ptr` 3→0).
- **Random-delay sources** (`max_delay` 0, 1, 2, 10) on 4 ports, plus a sink with random `out_rdy`, 64 messages per port → every message delivered exactly once, per-port order preserved, `num_msgs=256`.
- **Reset mid-stream** with `full=1` → output cleared the next cycle, the held message is never delivered, arbitration restarts at port 0.

Source files
------------

// File: rtl/vc_rr_msg_merge_pkg.sv
// rtl/vc_rr_msg_merge_pkg.sv - shared helpers for the round-robin message merge
package vc_rr_msg_merge_pkg;

  // Circular successor of idx in 0..n-1; explicit wrap so non-power-of-two n works.
  function automatic int unsigned rr_next(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/vc_rr_msg_merge_arb.sv
// rtl/vc_rr_msg_merge_arb.sv - round-robin priority arbiter with kill input
module vc_rr_arb_prio
  import vc_rr_msg_merge_pkg::*;
#(
  parameter int unsigned p_num_reqs = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [p_num_reqs-1:0]         reqs,
  input  logic                          kin,
  output logic [p_num_reqs-1:0]         grants,
  output logic [$clog2(p_num_reqs)-1:0] grant_idx
);

  localparam int unsigned p_src_nbits = $clog2(p_num_reqs);

  logic [p_src_nbits-1:0] ptr;
  logic                   found;
  int unsigned            idx;

  // Scan requesters starting at ptr, wrapping around the requester count.
  always_comb begin
    grants    = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < p_num_reqs; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= p_num_reqs) idx = idx - p_num_reqs;
      if (!found && reqs[idx]) begin
        found       = 1'b1;
        grants[idx] = 1'b1;
        grant_idx   = p_src_nbits'(idx);
      end
    end
    if (kin) grants = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (!kin && found) begin
      ptr <= p_src_nbits'(rr_next(32'(grant_idx), p_num_reqs));
    end
  end

endmodule

// File: rtl/vc_rr_msg_merge.sv
// rtl/vc_rr_msg_merge.sv - round-robin merge of val/rdy streams into one registered output
module vc_rr_msg_merge
  import vc_rr_msg_merge_pkg::*;
#(
  parameter int unsigned p_msg_nbits = 8,
  parameter int unsigned p_num_reqs  = 4,
  parameter int unsigned p_src_nbits = $clog2(p_num_reqs)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [p_num_reqs-1:0]             in_val,
  output logic [p_num_reqs-1:0]             in_rdy,
  input  logic [p_num_reqs*p_msg_nbits-1:0] in_msg,
  output logic                              out_val,
  input  logic                              out_rdy,
  output logic [p_msg_nbits-1:0]            out_msg,
  output logic [p_src_nbits-1:0]            out_src,
  output logic [31:0]                       num_msgs
);

  logic                   full;
  logic [p_msg_nbits-1:0] msg_reg;
  logic [p_src_nbits-1:0] src_reg;
  logic                   can_accept;
  logic                   in_xfer;
  logic                   out_xfer;
  logic [p_num_reqs-1:0]  grants;
  logic [p_src_nbits-1:0] grant_idx;
  logic [p_msg_nbits-1:0] req_msg [p_num_reqs];

  assign can_accept = !reset && (!full || out_rdy);

  vc_rr_arb_prio #(
    .p_num_reqs (p_num_reqs)
  ) arb (
    .clk       (clk),
    .reset     (reset),
    .reqs      (in_val),
    .kin       (!can_accept),
    .grants    (grants),
    .grant_idx (grant_idx)
  );

  // Grants are already masked by the kill input, so a grant is a transfer.
  assign in_rdy   = grants;
  assign in_xfer  = |grants;
  assign out_xfer = full && out_rdy;

  always_comb begin
    for (int unsigned i = 0; i < p_num_reqs; i++) begin
      req_msg[i] = in_msg[i*p_msg_nbits +: p_msg_nbits];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full     <= 1'b0;
      msg_reg  <= '0;
      src_reg  <= '0;
      num_msgs <= '0;
    end else begin
      if (in_xfer) begin
        full    <= 1'b1;
        msg_reg <= req_msg[grant_idx];
        src_reg <= grant_idx;
      end else if (out_xfer) begin
        full <= 1'b0;
      end
      if (out_xfer) num_msgs <= num_msgs + 32'd1;
    end
  end

  assign out_val = full;
  assign out_msg = msg_reg;
  assign out_src = src_reg;

endmodule

// File: tb/tb_vc_rr_msg_merge.sv
// tb/tb_vc_rr_msg_merge.sv - directed and random-delay bench for vc_rr_msg_merge
module tb_vc_rr_msg_merge;

  logic        clk;
  logic        reset;
  logic [3:0]  in_val;
  logic [3:0]  in_rdy;
  logic [31:0] in_msg;
  logic        out_val;
  logic        out_rdy;
  logic [7:0]  out_msg;
  logic [1:0]  out_src;
  logic [31:0] num_msgs;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q [4][$];

  vc_rr_msg_merge #(.p_msg_nbits(8), .p_num_reqs(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_msg   (in_msg),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_msg  (out_msg),
    .out_src  (out_src),
    .num_msgs (num_msgs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task tick;
    @(posedge clk);
    #1;
  endtask

  task trace;
    $display("%t %b/%b | %0d:%h", $time, in_val, in_rdy, out_src, out_msg);
  endtask

  task do_reset;
    reset = 1'b1; in_val = '0; out_rdy = 1'b0;
    tick; tick;
    reset = 1'b0;
  endtask

  task test_reset;
    reset = 1'b1; in_val = 4'b1111; out_rdy = 1'b1;
    in_msg = {8'h43, 8'h32, 8'h21, 8'h10};
    tick; tick;
    n_checks++; if (in_rdy !== 4'b0000) begin n_fail++; $display("FAIL reset_in_rdy got %b want 0000", in_rdy); end
    n_checks++; if (out_val !== 1'b0) begin n_fail++; $display("FAIL reset_out_val got %b want 0", out_val); end
    n_checks++; if (out_src !== 2'd0) begin n_fail++; $display("FAIL reset_out_src got %0d want 0", out_src); end
    n_checks++; if (out_msg !== 8'h00) begin n_fail++; $display("FAIL reset_out_msg got %h want 00", out_msg); end
    n_checks++; if (num_msgs !== 32'd0) begin n_fail++; $display("FAIL reset_num_msgs got %0d want 0", num_msgs); end
    reset = 1'b0;
    #1;
    n_checks++; if (in_rdy !== 4'b0001) begin n_fail++; $display("FAIL post_reset_in_rdy got %b want 0001", in_rdy); end
  endtask

  task test_all_valid;
    logic [7:0] data [4];
    data = '{8'h10, 8'h21, 8'h32, 8'h43};
    do_reset;
    in_msg = {8'h43, 8'h32, 8'h21, 8'h10};
    in_val = 4'b1111; out_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick;
      trace;
      n_checks++; if (out_val !== 1'b1) begin n_fail++; $display("FAIL all_valid_out_val[%0d] got %b want 1", k, out_val); end
      n_checks++; if (out_src !== 2'(k % 4)) begin n_fail++; $display("FAIL all_valid_src[%0d] got %0d want %0d", k, out_src, k % 4); end
      n_checks++; if (out_msg !== data[k % 4]) begin n_fail++; $display("FAIL all_valid_msg[%0d] got %h want %h", k, out_msg, data[k % 4]); end
      n_checks++; if (num_msgs !== 32'(k)) begin n_fail++; $display("FAIL all_valid_num[%0d] got %0d want %0d", k, num_msgs, k); end
    end
    in_val = '0;
    tick;
    n_checks++; if (num_msgs !== 32'd8) begin n_fail++; $display("FAIL all_valid_num_final got %0d want 8", num_msgs); end
    n_checks++; if (out_val !== 1'b0) begin n_fail++; $display("FAIL all_valid_drain got %b want 0", out_val); end
  endtask

  task test_backpressure;
    do_reset;
    in_msg = {8'h43, 8'h32, 8'h21, 8'h10};
    in_val = 4'b1111; out_rdy = 1'b1;
    tick; tick;
    out_rdy = 1'b0;
    #1;
    n_checks++; if (in_rdy !== 4'b0000) begin n_fail++; $display("FAIL bp_in_rdy_first got %b want 0000", in_rdy); end
    for (int k = 0; k < 3; k++) begin
      tick;
      n_checks++; if (out_val !== 1'b1 || out_msg !== 8'h21 || out_src !== 2'd1) begin
        n_fail++; $display("FAIL bp_hold[%0d] got val=%b msg=%h src=%0d want 1/21/1", k, out_val, out_msg, out_src);
      end
      n_checks++; if (in_rdy !== 4'b0000) begin n_fail++; $display("FAIL bp_in_rdy[%0d] got %b want 0000", k, in_rdy); end
      n_checks++; if (num_msgs !== 32'd1) begin n_fail++; $display("FAIL bp_num[%0d] got %0d want 1", k, num_msgs); end
    end
    out_rdy = 1'b1;
    #1;
    n_checks++; if (in_rdy !== 4'b0100) begin n_fail++; $display("FAIL bp_resume_rdy got %b want 0100", in_rdy); end
    tick;
    n_checks++; if (out_src !== 2'd2 || out_msg !== 8'h32) begin
      n_fail++; $display("FAIL bp_resume_out got %0d:%h want 2:32", out_src, out_msg);
    end
    n_checks++; if (num_msgs !== 32'd2) begin n_fail++; $display("FAIL bp_resume_num got %0d want 2", num_msgs); end
    in_val = '0;
  endtask

  task test_sparse;
    do_reset;
    in_msg = {8'h43, 8'h32, 8'h21, 8'h10};
    out_rdy = 1'b1;
    in_val = 4'b1000;
    #1;
    n_checks++; if (in_rdy !== 4'b1000) begin n_fail++; $display("FAIL sparse_rdy3 got %b want 1000", in_rdy); end
    tick;
    n_checks++; if (out_src !== 2'd3 || out_msg !== 8'h43) begin
      n_fail++; $display("FAIL sparse_out3 got %0d:%h want 3:43", out_src, out_msg);
    end
    in_val = 4'b1001;
    #1;
    n_checks++; if (in_rdy !== 4'b0001) begin n_fail++; $display("FAIL sparse_wrap_rdy got %b want 0001", in_rdy); end
    tick;
    n_checks++; if (out_src !== 2'd0 || out_msg !== 8'h10) begin
      n_fail++; $display("FAIL sparse_out0 got %0d:%h want 0:10", out_src, out_msg);
    end
    in_val = 4'b1010;
    #1;
    n_checks++; if (in_rdy !== 4'b0010) begin n_fail++; $display("FAIL sparse_rdy1 got %b want 0010", in_rdy); end
    tick;
    in_val = '0;
    tick;
    n_checks++; if (num_msgs !== 32'd3) begin n_fail++; $display("FAIL sparse_num got %0d want 3", num_msgs); end
  endtask

  task test_random;
    int unsigned maxd [4];
    int sent [4];
    int wait_c [4];
    int recv_total;
    int cyc;
    logic [3:0] fire;
    logic       ofire;
    logic [1:0] obs_src;
    logic [7:0] obs_msg;
    logic [7:0] head;
    maxd = '{0, 1, 2, 10};
    for (int i = 0; i < 4; i++) begin sent[i] = 0; wait_c[i] = 0; exp_q[i].delete(); end
    recv_total = 0; cyc = 0;
    do_reset;
    while (recv_total < 256 && cyc < 8000) begin
      for (int i = 0; i < 4; i++) begin
        in_val[i] = (sent[i] < 64) && (wait_c[i] == 0);
        in_msg[i*8 +: 8] = {2'(i), 6'(sent[i])};
      end
      out_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      fire = in_val & in_rdy; ofire = out_val & out_rdy;
      obs_src = out_src; obs_msg = out_msg;
      tick;
      for (int i = 0; i < 4; i++) begin
        if (fire[i]) begin
          exp_q[i].push_back({2'(i), 6'(sent[i])});
          sent[i]++;
          wait_c[i] = int'($urandom_range(0, maxd[i]));
        end else if (!in_val[i] && wait_c[i] > 0) begin
          wait_c[i]--;
        end
      end
      if (ofire) begin
        n_checks++;
        if (exp_q[obs_src].size() == 0) begin
          n_fail++; $display("FAIL rand_unexpected got %0d:%h want nothing from port %0d", obs_src, obs_msg, obs_src);
        end else begin
          head = exp_q[obs_src].pop_front();
          if (obs_msg !== head) begin
            n_fail++; $display("FAIL rand_order got %0d:%h want %0d:%h", obs_src, obs_msg, obs_src, head);
          end
        end
        recv_total++;
      end
      cyc++;
    end
    in_val = '0; out_rdy = 1'b0;
    n_checks++; if (recv_total != 256) begin n_fail++; $display("FAIL rand_timeout got %0d msgs want 256", recv_total); end
    n_checks++; if (num_msgs !== 32'd256) begin n_fail++; $display("FAIL rand_num_msgs got %0d want 256", num_msgs); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (exp_q[i].size() != 0) begin
        n_fail++; $display("FAIL rand_undelivered port %0d got %0d left want 0", i, exp_q[i].size());
      end
    end
  endtask

  task test_reset_mid;
    do_reset;
    in_msg = {8'h43, 8'h32, 8'h21, 8'h10};
    out_rdy = 1'b0;
    in_val = 4'b0100;
    tick;
    in_val = '0;
    n_checks++; if (out_val !== 1'b1 || out_msg !== 8'h32) begin
      n_fail++; $display("FAIL mid_loaded got val=%b msg=%h want 1/32", out_val, out_msg);
    end
    reset = 1'b1; in_val = 4'b1111;
    #1;
    n_checks++; if (in_rdy !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_rdy got %b want 0000", in_rdy); end
    tick;
    n_checks++; if (out_val !== 1'b0 || out_msg !== 8'h00 || out_src !== 2'd0) begin
      n_fail++; $display("FAIL mid_cleared got val=%b msg=%h src=%0d want 0/00/0", out_val, out_msg, out_src);
    end
    reset = 1'b0; out_rdy = 1'b1;
    #1;
    n_checks++; if (in_rdy !== 4'b0001) begin n_fail++; $display("FAIL mid_restart_rdy got %b want 0001", in_rdy); end
    tick;
    n_checks++; if (out_src !== 2'd0 || out_msg !== 8'h10) begin
      n_fail++; $display("FAIL mid_restart_out got %0d:%h want 0:10", out_src, out_msg);
    end
    tick;
    n_checks++; if (out_src !== 2'd1 || out_msg !== 8'h21) begin
      n_fail++; $display("FAIL mid_next_out got %0d:%h want 1:21", out_src, out_msg);
    end
    in_val = '0;
  endtask

  initial begin
    reset = 1'b1; in_val = '0; in_msg = '0; out_rdy = 1'b0;
    test_reset;
    test_all_valid;
    test_backpressure;
    test_sparse;
    test_random;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
